// File: rtl/nukv_pkg.sv
// Shared types and helpers for the NUKV hash-table read-command issuer.
// Source ids double as bit positions in the arbiter request/grant vectors.
package nukv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    localparam int SRC_INPUT    = 0;
    localparam int SRC_FEEDBACK = 1;

    localparam logic RR_LAST_INPUT    = 1'b0;
    localparam logic RR_LAST_FEEDBACK = 1'b1;

    function automatic int way_slice_width(input int hash_width, input int num_ways);
        return hash_width / num_ways;
    endfunction

    function automatic int way_cnt_width(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

endpackage

// File: rtl/nukv_rr_arb2.sv
// Two-requester arbiter (input vs feedback) producing a one-hot grant.
// Either strict feedback priority, or alternation when both request.
module nukv_rr_arb2
    import nukv_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio_mode,
    input  logic       rr_last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[SRC_FEEDBACK] &&
            (prio_mode || !req[SRC_INPUT] || (rr_last == RR_LAST_INPUT))) begin
            grant[SRC_FEEDBACK] = 1'b1;
        end else if (req[SRC_INPUT]) begin
            grant[SRC_INPUT] = 1'b1;
        end
    end

endmodule

// File: rtl/nukv_ht_read_nway.sv
// Hash-table read-command issuer: captures one request, issues NUM_WAYS bucket reads,
// then forwards the captured word. Handshakes: a transfer happens on a clock edge where valid && ready.
module nukv_ht_read_nway
    import nukv_pkg::*;
#(
    parameter int KEY_WIDTH         = 128,
    parameter int META_WIDTH        = 96,
    parameter int HASHADDR_WIDTH    = 64,
    parameter int MEMADDR_WIDTH     = 21,
    parameter int NUM_WAYS          = 2,
    parameter int FEEDBACK_PRIORITY = 0,
    parameter int CMD_WIDTH         = 32
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [HASHADDR_WIDTH+KEY_WIDTH+META_WIDTH-1:0] input_data,
    input  logic                                            input_valid,
    output logic                                            input_ready,
    input  logic [HASHADDR_WIDTH+KEY_WIDTH+META_WIDTH-1:0] feedback_data,
    input  logic                                            feedback_valid,
    output logic                                            feedback_ready,
    output logic [HASHADDR_WIDTH+KEY_WIDTH+META_WIDTH-1:0] output_data,
    output logic                                            output_valid,
    input  logic                                            output_ready,
    output logic [CMD_WIDTH-1:0]                            rdcmd_data,
    output logic                                            rdcmd_valid,
    input  logic                                            rdcmd_ready,
    output logic [31:0]                                     stat_lookups
);

    localparam int DW      = HASHADDR_WIDTH + KEY_WIDTH + META_WIDTH;
    localparam int SLICE_W = way_slice_width(HASHADDR_WIDTH, NUM_WAYS);
    localparam int WCW     = way_cnt_width(NUM_WAYS);
    localparam logic [WCW-1:0] LAST_WAY = WCW'(NUM_WAYS - 1);

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   hold;
    logic [DW-1:0]   sel_data;
    logic [WCW-1:0]  way_cnt;
    logic [WCW-1:0]  way_nxt;
    logic            rr_last;
    logic [31:0]     stat_cnt;
    logic [1:0]      grant;
    logic            accept;
    logic            cmd_fire;
    logic            out_fire;
    logic            last_way;

    // Bucket address of one way: a fixed slice of the hash, zero-extended to the command width.
    function automatic logic [CMD_WIDTH-1:0] way_cmd(input logic [DW-1:0] word,
                                                     input logic [WCW-1:0] idx);
        logic [HASHADDR_WIDTH-1:0] hash;
        logic [CMD_WIDTH-1:0]      cmd;
        hash = word[DW-1 -: HASHADDR_WIDTH];
        cmd  = '0;
        cmd[MEMADDR_WIDTH-1:0] = hash[int'(idx)*SLICE_W +: MEMADDR_WIDTH];
        return cmd;
    endfunction

    nukv_rr_arb2 u_arb (
        .req       ({feedback_valid, input_valid}),
        .prio_mode (FEEDBACK_PRIORITY != 0),
        .rr_last   (rr_last),
        .grant     (grant)
    );

    assign sel_data     = grant[SRC_FEEDBACK] ? feedback_data : input_data;
    assign last_way     = (way_cnt == LAST_WAY);
    assign way_nxt      = last_way ? '0 : way_cnt + 1'b1;
    assign cmd_fire     = rdcmd_valid && rdcmd_ready;
    assign out_fire     = output_valid && output_ready;
    assign stat_lookups = stat_cnt;

    always_comb begin
        state_nxt      = state;
        input_ready    = 1'b0;
        feedback_ready = 1'b0;
        accept         = 1'b0;
        case (state)
            ST_IDLE: begin
                input_ready    = grant[SRC_INPUT];
                feedback_ready = grant[SRC_FEEDBACK];
                accept         = |grant;
                if (accept) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cmd_fire && last_way) state_nxt = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_fire) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold         <= '0;
            way_cnt      <= '0;
            rr_last      <= RR_LAST_FEEDBACK;
            output_data  <= '0;
            output_valid <= 1'b0;
            rdcmd_data   <= '0;
            rdcmd_valid  <= 1'b0;
            stat_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        hold        <= sel_data;
                        rr_last     <= grant[SRC_FEEDBACK] ? RR_LAST_FEEDBACK : RR_LAST_INPUT;
                        stat_cnt    <= stat_cnt + 32'd1;
                        rdcmd_data  <= way_cmd(sel_data, WCW'(0));
                        rdcmd_valid <= 1'b1;
                        way_cnt     <= '0;
                    end
                end
                ST_ISSUE: begin
                    // Output is only raised once the final command has been taken.
                    if (cmd_fire) begin
                        if (last_way) begin
                            rdcmd_valid  <= 1'b0;
                            output_data  <= hold;
                            output_valid <= 1'b1;
                        end else begin
                            way_cnt    <= way_nxt;
                            rdcmd_data <= way_cmd(hold, way_nxt);
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (out_fire) output_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nukv_ht_read_nway.sv
// Directed bench for nukv_ht_read_nway: a 2-way round-robin instance and a 4-way
// feedback-priority instance share one stimulus bus selected by sel.
module tb_nukv_ht_read_nway;

    localparam int DW = 64 + 128 + 96;

    typedef struct {
        logic [63:0]  hash;
        logic [127:0] key;
        logic [95:0]  meta;
        logic [31:0]  exp_cmd0;
        logic [31:0]  exp_cmd1;
    } vec_t;

    logic clk;
    logic rst;
    logic sel;
    logic [DW-1:0] in_data, fb_data;
    logic in_valid, fb_valid, out_ready, cmd_ready;

    logic [DW-1:0] out_data;
    logic [31:0]   cmd_data, stat;
    logic          in_ready, fb_ready, out_valid, cmd_valid;

    logic          a_in_valid, a_fb_valid, a_out_ready, a_cmd_ready;
    logic          a_in_ready, a_fb_ready, a_out_valid, a_cmd_valid;
    logic [DW-1:0] a_out_data;
    logic [31:0]   a_cmd_data, a_stat;
    logic          b_in_valid, b_fb_valid, b_out_ready, b_cmd_ready;
    logic          b_in_ready, b_fb_ready, b_out_valid, b_cmd_valid;
    logic [DW-1:0] b_out_data;
    logic [31:0]   b_cmd_data, b_stat;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic [31:0]   cmd_q[$];
    vec_t          vecs[5];

    assign a_in_valid  = !sel && in_valid;
    assign a_fb_valid  = !sel && fb_valid;
    assign a_out_ready = sel || out_ready;
    assign a_cmd_ready = sel || cmd_ready;
    assign b_in_valid  = sel && in_valid;
    assign b_fb_valid  = sel && fb_valid;
    assign b_out_ready = !sel || out_ready;
    assign b_cmd_ready = !sel || cmd_ready;

    assign in_ready  = sel ? b_in_ready  : a_in_ready;
    assign fb_ready  = sel ? b_fb_ready  : a_fb_ready;
    assign out_valid = sel ? b_out_valid : a_out_valid;
    assign out_data  = sel ? b_out_data  : a_out_data;
    assign cmd_valid = sel ? b_cmd_valid : a_cmd_valid;
    assign cmd_data  = sel ? b_cmd_data  : a_cmd_data;
    assign stat      = sel ? b_stat      : a_stat;

    nukv_ht_read_nway #(.NUM_WAYS(2), .FEEDBACK_PRIORITY(0), .MEMADDR_WIDTH(21)) u_a (
        .clk(clk), .rst(rst),
        .input_data(in_data), .input_valid(a_in_valid), .input_ready(a_in_ready),
        .feedback_data(fb_data), .feedback_valid(a_fb_valid), .feedback_ready(a_fb_ready),
        .output_data(a_out_data), .output_valid(a_out_valid), .output_ready(a_out_ready),
        .rdcmd_data(a_cmd_data), .rdcmd_valid(a_cmd_valid), .rdcmd_ready(a_cmd_ready),
        .stat_lookups(a_stat)
    );

    nukv_ht_read_nway #(.NUM_WAYS(4), .FEEDBACK_PRIORITY(1), .MEMADDR_WIDTH(16)) u_b (
        .clk(clk), .rst(rst),
        .input_data(in_data), .input_valid(b_in_valid), .input_ready(b_in_ready),
        .feedback_data(fb_data), .feedback_valid(b_fb_valid), .feedback_ready(b_fb_ready),
        .output_data(b_out_data), .output_valid(b_out_valid), .output_ready(b_out_ready),
        .rdcmd_data(b_cmd_data), .rdcmd_valid(b_cmd_valid), .rdcmd_ready(b_cmd_ready),
        .stat_lookups(b_stat)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard helpers
    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_word(input logic [63:0] h, input logic [127:0] k,
                                              input logic [95:0] m);
        return {h, k, m};
    endfunction

    function automatic logic [DW-1:0] src_word(input logic src, input int tag);
        logic [7:0] id;
        id = {src ? 4'hF : 4'h1, 4'(tag)};
        return mk_word({56'h0, id}, {120'h0, id}, {88'h0, id});
    endfunction

    // driver: one full lookup on the 2-way instance with both readies high
    task automatic run_vec(input vec_t v, input logic [31:0] exp_stat);
        logic [DW-1:0] w;
        w = mk_word(v.hash, v.key, v.meta);
        @(negedge clk);
        in_data = w; in_valid = 1'b1;
        #1;
        chk1("vec_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk1("vec_cmd0_valid", cmd_valid, 1'b1);
        chk32("vec_cmd0", cmd_data, v.exp_cmd0);
        chk1("vec_out_early0", out_valid, 1'b0);
        chk32("vec_stat", stat, exp_stat);
        @(negedge clk);
        #1;
        chk1("vec_cmd1_valid", cmd_valid, 1'b1);
        chk32("vec_cmd1", cmd_data, v.exp_cmd1);
        chk1("vec_out_early1", out_valid, 1'b0);
        @(negedge clk);
        #1;
        chk1("vec_cmd_done", cmd_valid, 1'b0);
        chk1("vec_out_valid", out_valid, 1'b1);
        chkw("vec_out_data", out_data, w);
        @(negedge clk);
        #1;
        chk1("vec_out_clear", out_valid, 1'b0);
    endtask

    // driver: both sources stream tags 1..4; outputs compared against exp_q order
    task automatic run_arb(input string name);
        int ii, fi, cyc;
        ii = 0; fi = 0; cyc = 0;
        out_ready = 1'b1; cmd_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            in_valid = (ii < 4);
            fb_valid = (fi < 4);
            in_data  = src_word(1'b0, ii + 1);
            fb_data  = src_word(1'b1, fi + 1);
            #1;
            chk1({name, "_one_hot"}, in_ready && fb_ready, 1'b0);
            if (in_valid && in_ready) ii++;
            if (fb_valid && fb_ready) fi++;
            if (out_valid && out_ready) chkw({name, "_order"}, out_data, exp_q.pop_front());
            cyc++;
        end
        chk1({name, "_done"}, exp_q.size() == 0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; fb_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] w1, w2, w3, wb;
        int  ncyc;
        logic done;

        vecs[0] = '{64'h0000_0005_0000_0003, 128'h1111, 96'h01, 32'h3, 32'h5};
        vecs[1] = '{64'h1234_5678_9ABC_DEF0, 128'h2222, 96'h02, 32'h1C_DEF0, 32'h14_5678};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 128'h3333, 96'h03, 32'h1F_FFFF, 32'h1F_FFFF};
        vecs[3] = '{64'h0000_0007_0000_0007, 128'h4444, 96'h04, 32'h7, 32'h7};
        vecs[4] = '{64'h0030_0000_0010_0000, 128'h5555, 96'h05, 32'h10_0000, 32'h10_0000};

        rst = 1'b1; sel = 1'b0;
        in_data = '0; fb_data = '0; in_valid = 1'b0; fb_valid = 1'b0;
        out_ready = 1'b1; cmd_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_cmd_valid", cmd_valid, 1'b0);
        chk32("rst_cmd_data", cmd_data, 32'h0);
        chkw("rst_out_data", out_data, '0);
        chk32("rst_stat", stat, 32'h0);
        chk1("rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // table-driven lookups
        for (int i = 0; i < 5; i++) run_vec(vecs[i], 32'(i + 1));

        // output back-pressure for 10 cycles, pending input must wait
        w1 = mk_word(64'h0000_0011_0000_0022, 128'hA1, 96'hA1);
        w2 = mk_word(64'h0000_0033_0000_0044, 128'hA2, 96'hA2);
        @(negedge clk);
        out_ready = 1'b0; in_data = w1; in_valid = 1'b1;
        @(negedge clk);
        in_data = w2;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            #1;
            chk1("bp_in_ready", in_ready, 1'b0);
            if (i >= 1) begin
                chk1("bp_out_valid", out_valid, 1'b1);
                chkw("bp_out_data", out_data, w1);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk1("bp_out_released", out_valid, 1'b0);
        chk1("bp_resume_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk32("bp_w2_cmd0", cmd_data, 32'h44);
        chk32("bp_stat", stat, 32'd7);
        ncyc = 0;
        while (!out_valid && ncyc < 10) begin
            @(negedge clk);
            #1;
            ncyc++;
        end
        chk1("bp_w2_out_valid", out_valid, 1'b1);
        chkw("bp_w2_out_data", out_data, w2);
        repeat (2) @(negedge clk);

        // reset while the second way is pending
        w3 = mk_word(64'h0000_0066_0000_0055, 128'hC3, 96'hC3);
        @(negedge clk);
        in_data = w3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk32("mid_cmd1", cmd_data, 32'h66);
        rst = 1'b1;
        #1;
        chk1("mid_rst_cmd_valid", cmd_valid, 1'b0);
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        chk32("mid_rst_cmd_data", cmd_data, 32'h0);
        chk32("mid_rst_stat", stat, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[1], 32'd1);

        // statistic counter wrap
        @(negedge clk);
        force u_a.stat_cnt = 32'hFFFF_FFFF;
        #1;
        release u_a.stat_cnt;
        #1;
        chk32("wrap_preload", stat, 32'hFFFF_FFFF);
        run_vec(vecs[0], 32'h0);

        // round-robin arbitration from reset (rr_last starts as feedback)
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            exp_q.push_back(src_word(1'b0, t));
            exp_q.push_back(src_word(1'b1, t));
        end
        run_arb("rr");

        // 4-way instance: command order and hold under a toggling rdcmd_ready
        sel = 1'b1;
        wb = mk_word(64'h000D_000C_000B_000A, 128'hB0, 96'hB0);
        cmd_q = '{32'hA, 32'hB, 32'hC, 32'hD};
        out_ready = 1'b0; cmd_ready = 1'b0;
        @(negedge clk);
        in_data = wb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ncyc = 0; done = 1'b0;
        while (!done && ncyc < 40) begin
            #1;
            if (cmd_q.size() != 0) chk1("nway_out_early", out_valid, 1'b0);
            if (cmd_valid) begin
                if (cmd_q.size() == 0) chk1("nway_extra_cmd", cmd_valid, 1'b0);
                else chk32("nway_cmd", cmd_data, cmd_q[0]);
            end
            cmd_ready = (ncyc % 2 == 1);
            if (cmd_valid && cmd_ready && cmd_q.size() != 0) void'(cmd_q.pop_front());
            if (out_valid) done = 1'b1;
            @(negedge clk);
            ncyc++;
        end
        chk1("nway_done", done, 1'b1);
        chk1("nway_all_cmds", cmd_q.size() == 0, 1'b1);
        #1;
        chkw("nway_out_data", out_data, wb);
        chk32("nway_stat", stat, 32'd1);
        out_ready = 1'b1; cmd_ready = 1'b1;
        @(negedge clk);
        #1;
        chk1("nway_out_clear", out_valid, 1'b0);

        // feedback strictly wins on the priority instance
        for (int t = 1; t <= 4; t++) exp_q.push_back(src_word(1'b1, t));
        for (int t = 1; t <= 4; t++) exp_q.push_back(src_word(1'b0, t));
        run_arb("prio");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
